// File: rtl/water_level_pkg.sv
// Shared types and elaboration helpers for the multi-channel water-level debouncer.
package water_level_pkg;

  localparam logic SW_DRY = 1'b1;
  localparam logic SW_WET = 1'b0;

  typedef struct packed {
    logic stable;
    logic rise;
    logic fall;
  } chan_out_t;

  function automatic int ms_to_cycles(input int clk_hz, input int ms);
    return (clk_hz / 1000) * ms;
  endfunction

  function automatic int cnt_width(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/water_level_chan.sv
// One float-switch channel: 2-flop synchroniser, stable-time debouncer, rise/fall pulses.
module water_level_chan
  import water_level_pkg::*;
#(
  parameter int   COUNT_LIMIT = 8,
  parameter logic RESET_BIT   = SW_DRY
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      din,
  output chan_out_t q
);

  localparam int CW = cnt_width(COUNT_LIMIT);

  logic          sync1, sync2;
  logic [CW-1:0] cnt;

  // The count only advances while sync2 disagrees with the committed level, so any
  // bounce back restarts it and the commit edge always returns it to zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1    <= RESET_BIT;
      sync2    <= RESET_BIT;
      cnt      <= '0;
      q.stable <= RESET_BIT;
      q.rise   <= 1'b0;
      q.fall   <= 1'b0;
    end else begin
      sync1  <= din;
      sync2  <= sync1;
      q.rise <= 1'b0;
      q.fall <= 1'b0;
      if (sync2 == q.stable) begin
        cnt <= '0;
      end else if (cnt < CW'(COUNT_LIMIT - 1)) begin
        cnt <= cnt + CW'(1);
      end else begin
        q.stable <= sync2;
        q.rise   <= sync2;
        q.fall   <= ~sync2;
        cnt      <= '0;
      end
    end
  end

endmodule

// File: rtl/water_level_array.sv
// N_CH stacked float-switch debouncer with fill-level decode and plausibility fault.
// Define WL_FAULT_STICKY_EN to make level_fault sticky until fault_clr.
module water_level_array
  import water_level_pkg::*;
#(
  parameter int              N_CH            = 4,
  parameter int              CLK_FREQ_HZ     = 50_000_000,
  parameter int              STABLE_MS       = 20,
  parameter int              COUNT_LIMIT_OVR = 0,
  parameter logic [N_CH-1:0] RESET_VAL       = '1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [N_CH-1:0]            signal_async,
  input  logic                       fault_clr,
  output logic [N_CH-1:0]            signal_stable,
  output logic [N_CH-1:0]            rise_pulse,
  output logic [N_CH-1:0]            fall_pulse,
  output logic [$clog2(N_CH+1)-1:0]  level,
  output logic                       level_fault
);

  localparam int COUNT_LIMIT = (COUNT_LIMIT_OVR != 0) ? COUNT_LIMIT_OVR
                                                      : ms_to_cycles(CLK_FREQ_HZ, STABLE_MS);
  localparam int LW = $clog2(N_CH + 1);

  if (COUNT_LIMIT < 2) begin : g_bad_limit
    $error("water_level_array: COUNT_LIMIT must be at least 2");
  end

  chan_out_t ch_q [N_CH];

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    water_level_chan #(
      .COUNT_LIMIT (COUNT_LIMIT),
      .RESET_BIT   (RESET_VAL[i])
    ) u_chan (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (signal_async[i]),
      .q       (ch_q[i])
    );
    assign signal_stable[i] = ch_q[i].stable;
    assign rise_pulse[i]    = ch_q[i].rise;
    assign fall_pulse[i]    = ch_q[i].fall;
  end

  // Returns {fault, level}; level stops at the first dry switch from the bottom.
  function automatic logic [LW:0] decode(input logic [N_CH-1:0] st);
    logic          dry_seen;
    logic [LW-1:0] lvl;
    logic          flt;
    dry_seen = 1'b0;
    lvl      = '0;
    flt      = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (st[i] == SW_DRY)  dry_seen = 1'b1;
      else if (!dry_seen)   lvl      = LW'(i + 1);
    end
    for (int i = 1; i < N_CH; i++) begin
      if (st[i] == SW_WET && st[i-1] == SW_DRY) flt = 1'b1;
    end
    return {flt, lvl};
  endfunction

  localparam logic [LW:0] DEC_RST = decode(RESET_VAL);

  logic [LW-1:0] level_now;
  logic          fault_now;

  always_comb begin
    {fault_now, level_now} = decode(signal_stable);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level       <= DEC_RST[LW-1:0];
      level_fault <= DEC_RST[LW];
    end else begin
      level <= level_now;
`ifdef WL_FAULT_STICKY_EN
      if (fault_now)      level_fault <= 1'b1;
      else if (fault_clr) level_fault <= 1'b0;
`else
      level_fault <= fault_now;
`endif
    end
  end

`ifndef WL_FAULT_STICKY_EN
  logic unused_fault_clr;
  assign unused_fault_clr = fault_clr;
`endif

endmodule
